// File: rtl/servo_bank.sv
// Multi-channel RC-servo PWM generator with a shared frame counter and frame-aligned position updates.
// Define SERVO_SLEW_EN to limit each channel's position change to SLEW_STEP per frame.
module servo_bank #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned VALUE_W   = 10,
  parameter int unsigned CLK_HZ    = 16000000,
  parameter int unsigned PERIOD_US = 20000,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned SLEW_STEP = 8,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WR_EN,
  input  logic [CH_W-1:0]     WR_CH,
  input  logic [VALUE_W-1:0]  WR_VALUE,
  input  logic [CHANNELS-1:0] ENABLE,
  output logic [CHANNELS-1:0] PWM,
  output logic                FRAME_START
);

  localparam int unsigned TPU      = CLK_HZ / 1000000;
  localparam int unsigned PERIOD_T = PERIOD_US * TPU;
  localparam int unsigned MIN_T    = MIN_US * TPU;
  localparam int unsigned SPAN_T   = (MAX_US - MIN_US) * TPU;
  localparam int unsigned CNT_W    = $clog2(PERIOD_T);
  localparam int unsigned SPAN_W   = $clog2(SPAN_T + 1);
  localparam int unsigned PROD_W   = VALUE_W + SPAN_W;

  localparam logic [VALUE_W-1:0] CENTER = VALUE_W'(1) << (VALUE_W - 1);

  localparam longint unsigned MaxPulse =
      64'(MIN_T) + ((((64'd1 << VALUE_W) - 64'd1) * 64'(SPAN_T)) >> VALUE_W);

  if (MaxPulse >= 64'(PERIOD_T)) begin : g_bad_period
    $error("servo_bank: longest pulse does not leave a low interval in the frame");
  end
  if ((CLK_HZ % 1000000) != 0 || MAX_US <= MIN_US || SLEW_STEP == 0) begin : g_bad_cfg
    $error("servo_bank: invalid clock, pulse range or slew configuration");
  end

  // Full-width product, truncated after the shift; no rounding.
  function automatic logic [CNT_W-1:0] pulse_of(input logic [VALUE_W-1:0] v);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(v) * PROD_W'(SPAN_T);
    return CNT_W'(MIN_T) + CNT_W'(prod >> VALUE_W);
  endfunction

  logic [CNT_W-1:0]                   fcnt_q;
  logic [CHANNELS-1:0][VALUE_W-1:0]   shadow_q, active_q, active_d;
  logic [CHANNELS-1:0]                en_act_q;
  logic                               frame_tick;

  assign frame_tick = (fcnt_q == '0);

`ifdef SERVO_SLEW_EN
  localparam logic [VALUE_W-1:0] STEP = VALUE_W'(SLEW_STEP);

  always_comb begin
    active_d = active_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (shadow_q[i] > active_q[i]) begin
        if ((shadow_q[i] - active_q[i]) > STEP) active_d[i] = active_q[i] + STEP;
        else                                    active_d[i] = shadow_q[i];
      end else if (shadow_q[i] < active_q[i]) begin
        if ((active_q[i] - shadow_q[i]) > STEP) active_d[i] = active_q[i] - STEP;
        else                                    active_d[i] = shadow_q[i];
      end
    end
  end
`else
  always_comb begin
    active_d = shadow_q;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      fcnt_q      <= '0;
      PWM         <= '0;
      FRAME_START <= 1'b0;
      en_act_q    <= '0;
      shadow_q    <= {CHANNELS{CENTER}};
      active_q    <= {CHANNELS{CENTER}};
    end else begin
      fcnt_q      <= (fcnt_q == CNT_W'(PERIOD_T - 1)) ? '0 : fcnt_q + CNT_W'(1);
      FRAME_START <= frame_tick;
      // Copy uses the pre-edge shadow, so a same-cycle write lands next frame.
      if (frame_tick) begin
        active_q <= active_d;
        en_act_q <= ENABLE;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (WR_EN && (WR_CH == CH_W'(i))) shadow_q[i] <= WR_VALUE;
        PWM[i] <= en_act_q[i] && !frame_tick && (fcnt_q <= pulse_of(active_q[i]));
      end
    end
  end

endmodule

// File: tb/tb_servo_bank.sv
// Scoreboard bench for servo_bank: a monitor measures every frame's pulses and the scenario
// tasks queue the frames they expect. Build with SERVO_SLEW_EN to add the slew scenario.
module tb_servo_bank;

  localparam int NCH      = 5;
  localparam int VW       = 10;
  localparam int PERIOD_T = 3000;  // 1500 us at 2 ticks/us
  localparam int MIN_T    = 1000;
  localparam int SPAN_T   = 1000;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic                WR_EN = 1'b0;
  logic [2:0]          WR_CH = '0;
  logic [VW-1:0]       WR_VALUE = '0;
  logic [NCH-1:0]      ENABLE = '1;
  logic [NCH-1:0]      PWM;
  logic                FRAME_START;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [NCH-1:0][15:0] w;
    logic [NCH-1:0][15:0] first;
    logic [15:0]          len;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];

  servo_bank #(
    .CHANNELS (NCH),
    .VALUE_W  (VW),
    .CLK_HZ   (2000000),
    .PERIOD_US(1500),
    .MIN_US   (500),
    .MAX_US   (1000),
    .SLEW_STEP(8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_EN      (WR_EN),
    .WR_CH      (WR_CH),
    .WR_VALUE   (WR_VALUE),
    .ENABLE     (ENABLE),
    .PWM        (PWM),
    .FRAME_START(FRAME_START)
  );

  always #5 CLK = ~CLK;

  function automatic int pulse_ref(input int v);
    return MIN_T + ((v * SPAN_T) >> VW);
  endfunction

  // Measure each frame: high-cycle count and first-high offset after FRAME_START, plus length.
  initial begin
    rec_t cur;
    int   cnt;
    bit   in_frame;
    in_frame = 1'b0;
    cnt = 0;
    cur = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        in_frame = 1'b0;
      end else if (FRAME_START) begin
        if (in_frame) begin
          cur.len = 16'(cnt);
          got_q.push_back(cur);
        end
        in_frame = 1'b1;
        cur = '0;
        cnt = 1;
      end else if (in_frame) begin
        for (int i = 0; i < NCH; i++) begin
          if (PWM[i]) begin
            if (cur.w[i] == 0) cur.first[i] = 16'(cnt);
            cur.w[i] = cur.w[i] + 16'd1;
          end
        end
        cnt++;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_frame(input logic [NCH-1:0] en, input logic [NCH-1:0][VW-1:0] vals);
    rec_t r;
    r = '0;
    r.len = 16'(PERIOD_T);
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        r.w[i]     = 16'(pulse_ref(int'(vals[i])));
        r.first[i] = 16'd1;
      end
    end
    exp_q.push_back(r);
  endtask

  task automatic write(input int ch, input int val);
    WR_EN = 1'b1;
    WR_CH = 3'(ch);
    WR_VALUE = VW'(val);
    tick();
    WR_EN = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    int budget;
    budget = PERIOD_T + 10;
    tick();
    while (!FRAME_START && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (!FRAME_START) begin
      failures++;
      $display("FAIL %s: frame start timeout, FRAME_START=%0b required 1", name, FRAME_START);
    end
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    WR_EN = 1'b0;
    tick(3);
    RST = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Pops measured frames against queued expectations.
  task automatic scoreboard_drain(input string name);
    int budget;
    rec_t e, g;
    budget = (exp_q.size() + 2) * PERIOD_T;
    while (got_q.size() < exp_q.size() && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (got_q.size() < exp_q.size()) begin
      failures++;
      $display("FAIL %s: frames seen %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int f = 0; exp_q.size() > 0 && got_q.size() > 0; f++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g.len !== e.len) begin
        failures++;
        $display("FAIL %s frame%0d len: got %0d required %0d", name, f, g.len, e.len);
      end
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (g.w[i] !== e.w[i] || g.first[i] !== e.first[i]) begin
          failures++;
          $display("FAIL %s frame%0d ch%0d: width %0d first %0d required width %0d first %0d",
                   name, f, i, g.w[i], g.first[i], e.w[i], e.first[i]);
        end
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  logic [NCH-1:0][VW-1:0] center;

  task automatic test_reset();
    RST = 1'b1;
    ENABLE = '1;
    tick(3);
    checks++;
    if (PWM !== '0 || FRAME_START !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: PWM=%b FRAME_START=%b required 0/0", PWM, FRAME_START);
    end
    RST = 1'b0;
    got_q.delete();
    exp_q.delete();
    push_frame('1, center);
    push_frame('1, center);
    wait_fs("reset_first_frame");
    checks++;
    if (PWM !== '0) begin
      failures++;
      $display("FAIL reset_rise: PWM=%b at FRAME_START required 0", PWM);
    end
    tick();
    checks++;
    if (PWM !== '1) begin
      failures++;
      $display("FAIL reset_rise: PWM=%b one cycle after FRAME_START required all ones", PWM);
    end
    scoreboard_drain("reset_center");
  endtask

  task automatic test_write_mid_frame();
    logic [NCH-1:0][VW-1:0] v;
    apply_reset();
    ENABLE = '1;
    v = center;
    v[0] = 10'h000;
    v[1] = 10'h3FF;
    push_frame('1, center);
    push_frame('1, v);
    wait_fs("mid_frame_start");
    tick(100);
    write(0, 'h000);
    write(1, 'h3FF);
    scoreboard_drain("write_mid_frame");
  endtask

  task automatic test_write_at_frame_start();
    logic [NCH-1:0][VW-1:0] v;
    apply_reset();
    v = center;
    v[2] = 10'h100;
    push_frame('1, center);
    push_frame('1, center);
    push_frame('1, v);
    wait_fs("fs_write_start");
    tick(PERIOD_T - 1);
    write(2, 'h100);
    checks++;
    if (FRAME_START !== 1'b1) begin
      failures++;
      $display("FAIL fs_write_align: FRAME_START=%b after write required 1", FRAME_START);
    end
    scoreboard_drain("write_at_frame_start");
  endtask

  task automatic test_bad_channel_enable();
    apply_reset();
    ENABLE = '1;
    push_frame('1, center);
    push_frame(5'b01010, center);
    wait_fs("badch_start");
    tick(50);
    write(5, 'h000);
    write(6, 'h3FF);
    write(7, 'h001);
    ENABLE = 5'b01010;
    tick(10);
    checks++;
    if (PWM !== '1) begin
      failures++;
      $display("FAIL enable_mid_frame: PWM=%b required all ones", PWM);
    end
    scoreboard_drain("bad_channel_enable");
    ENABLE = '1;
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset();
    ENABLE = '1;
    wait_fs("rst_mid_start");
    tick(10);
    write(0, 'h000);
    wait_fs("rst_mid_frame2");
    tick(1200);
    checks++;
    if (PWM !== 5'b11110) begin
      failures++;
      $display("FAIL rst_mid_pre: PWM=%b required 11110", PWM);
    end
    RST = 1'b1;
    tick();
    checks++;
    if (PWM !== '0 || FRAME_START !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_drop: PWM=%b FRAME_START=%b required 0/0", PWM, FRAME_START);
    end
    tick(2);
    RST = 1'b0;
    got_q.delete();
    exp_q.delete();
    push_frame('1, center);
    scoreboard_drain("reset_mid_pulse");
  endtask

`ifdef SERVO_SLEW_EN
  task automatic test_slew();
    logic [NCH-1:0][VW-1:0] v;
    apply_reset();
    ENABLE = '1;
    push_frame('1, center);
    for (int s = 1; s <= 5; s++) begin
      v = center;
      v[0] = (s >= 4) ? 10'h220 : VW'(10'h200 + 8 * s);
      push_frame('1, v);
    end
    wait_fs("slew_start");
    tick(20);
    write(0, 'h220);
    scoreboard_drain("slew");
  endtask
`endif

  initial begin
    center = {NCH{10'h200}};
    test_reset();
    test_write_mid_frame();
    test_write_at_frame_start();
    test_bad_channel_enable();
    test_reset_mid_pulse();
`ifdef SERVO_SLEW_EN
    test_slew();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
